// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the SCCB responder.
// Holds the FSM state enum, canonical bus addresses of the OV7670,
// the COM7 register location and helpers for its soft-reset bit.
package sccb_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID_BYTE,
        S_ID_ACK,
        S_SUB_BYTE,
        S_SUB_ACK,
        S_DATA_BYTE,
        S_DATA_ACK,
        S_RD_BYTE,
        S_RD_ACK,
        S_IGNORE
    } sccb_slv_state_t;

    localparam logic [7:0] SCCB_ID_WR   = 8'h42;
    localparam logic [7:0] SCCB_ID_RD   = 8'h43;
    localparam logic [7:0] REG_COM7     = 8'h12;
    localparam int         COM7_RST_BIT = 7;

    // True when a committed write requests the register-file soft reset.
    function automatic logic is_com7_reset(input logic [7:0] addr,
                                           input logic [7:0] data);
        return (addr == REG_COM7) && data[COM7_RST_BIT];
    endfunction

    // Value COM7 keeps after a soft reset: the written data minus the reset bit.
    function automatic logic [7:0] com7_after_reset(input logic [7:0] data);
        logic [7:0] r;
        r = data;
        r[COM7_RST_BIT] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// sccb_line_sync: brings SCL/SDA into the clk domain and flags bus events.
// Ports: clk/reset; scl, sda raw bus lines; scl_rise/scl_fall one-cycle edge
// strobes; sda_s synchronized data; start_det/stop_det bus condition strobes.
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    // Idle bus is high on both lines, so the chains reset to 1 to avoid
    // seeing a phantom falling edge when reset is released.
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl_now;
    logic                   sda_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync[0] <= scl;
            sda_sync[0] <= sda;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync[i] <= scl_sync[i-1];
                sda_sync[i] <= sda_sync[i-1];
            end
            scl_q <= scl_now;
            sda_q <= sda_now;
        end
    end

    assign scl_now  = scl_sync[SYNC_STAGES-1];
    assign sda_now  = sda_sync[SYNC_STAGES-1];

    assign scl_rise = scl_now & ~scl_q;
    assign scl_fall = ~scl_now & scl_q;
    assign sda_s    = sda_now;

    // SDA may only move while SCL is low during data transfer; a change with
    // SCL steady high across both sampled cycles is a START or STOP.
    assign start_det = scl_now & scl_q & sda_q & ~sda_now;
    assign stop_det  = scl_now & scl_q & ~sda_q & sda_now;

endmodule

// File: rtl/sccb_slave.sv
// sccb_slave: OV7670-style SCCB register-configuration responder.
// Ports: clk/reset; scl in, sda open-drain inout; dbg_addr/dbg_data register
// peek (1-cycle); wr_valid/wr_addr/wr_data commit strobe; rd_valid, id_err,
// soft_rst one-cycle pulses; busy high between START and STOP.
module sccb_slave
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ID      = SCCB_ID_WR[7:1],
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_valid,
    output logic       id_err,
    output logic       soft_rst,
    output logic       busy
);

    localparam logic [7:0] ID_WR = {DEV_ID, SCCB_ID_WR[0]};
    localparam logic [7:0] ID_RD = {DEV_ID, SCCB_ID_RD[0]};

    sccb_slv_state_t state;
    logic [2:0]      bit_cnt;
    logic [6:0]      shreg;
    logic [6:0]      tx;
    logic [7:0]      sub_addr;
    logic [7:0]      data_byte;
    logic            ack_on;
    logic            rd_mode;
    logic            sda_oe;

    logic            scl_rise;
    logic            scl_fall;
    logic            sda_s;
    logic            start_det;
    logic            stop_det;

    logic [7:0]      regs [256];
    logic [7:0]      rx_byte;
    logic [7:0]      rd_word;
    logic            commit;

    // Open-drain: only ever pull low. sda_oe is a flop with async reset, so
    // the line is released the instant reset asserts.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    sccb_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign rx_byte = {shreg, sda_s};
    assign rd_word = regs[sub_addr];

    // The data byte is committed on the falling edge that opens its ACK slot,
    // unless a bus condition wins in the same cycle.
    assign commit = (state == S_DATA_ACK) && !ack_on && scl_fall
                    && !start_det && !stop_det;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            tx        <= 7'd0;
            sub_addr  <= 8'h00;
            data_byte <= 8'h00;
            ack_on    <= 1'b0;
            rd_mode   <= 1'b0;
            sda_oe    <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            rd_valid  <= 1'b0;
            id_err    <= 1'b0;
            soft_rst  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            rd_valid <= 1'b0;
            id_err   <= 1'b0;
            soft_rst <= 1'b0;

            if (start_det) begin
                // Also covers repeated START: any partial byte is dropped.
                state   <= S_ID_BYTE;
                bit_cnt <= 3'd0;
                ack_on  <= 1'b0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop_det) begin
                state   <= S_IDLE;
                bit_cnt <= 3'd0;
                ack_on  <= 1'b0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_ID_BYTE, S_SUB_BYTE, S_DATA_BYTE: begin
                        if (scl_rise) begin
                            shreg <= rx_byte[6:0];
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                if (state == S_ID_BYTE) begin
                                    if (rx_byte == ID_WR) begin
                                        rd_mode <= 1'b0;
                                        state   <= S_ID_ACK;
                                    end else if (rx_byte == ID_RD) begin
                                        rd_mode <= 1'b1;
                                        state   <= S_ID_ACK;
                                    end else begin
                                        id_err <= 1'b1;
                                        state  <= S_IGNORE;
                                    end
                                end else if (state == S_SUB_BYTE) begin
                                    sub_addr <= rx_byte;
                                    state    <= S_SUB_ACK;
                                end else begin
                                    data_byte <= rx_byte;
                                    state     <= S_DATA_ACK;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end

                    // ack_on splits the ACK slot: first falling edge starts
                    // driving low, second one releases and moves on.
                    S_ID_ACK, S_SUB_ACK, S_DATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                ack_on <= 1'b1;
                                sda_oe <= 1'b1;
                                if (commit) begin
                                    wr_valid <= 1'b1;
                                    wr_addr  <= sub_addr;
                                    wr_data  <= data_byte;
                                    soft_rst <= is_com7_reset(sub_addr, data_byte);
                                end
                            end else begin
                                ack_on  <= 1'b0;
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd0;
                                if (state == S_ID_ACK) begin
                                    if (rd_mode) begin
                                        // Load and present the MSB right away.
                                        tx       <= rd_word[6:0];
                                        sda_oe   <= ~rd_word[7];
                                        rd_valid <= 1'b1;
                                        state    <= S_RD_BYTE;
                                    end else begin
                                        state <= S_SUB_BYTE;
                                    end
                                end else if (state == S_SUB_ACK) begin
                                    state <= S_DATA_BYTE;
                                end else begin
                                    // No sub-address increment: further bytes are not ACKed.
                                    state <= S_IGNORE;
                                end
                            end
                        end
                    end

                    S_RD_BYTE: begin
                        if (scl_rise) begin
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                state   <= S_RD_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else if (scl_fall) begin
                            sda_oe <= ~tx[6];
                            tx     <= {tx[5:0], 1'b0};
                        end
                    end

                    // Release for the master's ACK/NACK, then ignore the rest.
                    S_RD_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                        end else if (scl_rise) begin
                            state <= S_IGNORE;
                        end
                    end

                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Register file. Soft reset lands the cycle after the COM7 commit, which
    // had already written the raw value; COM7 keeps it minus the reset bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (soft_rst) begin
            for (int i = 0; i < 256; i++) begin
                regs[i] <= 8'h00;
            end
            regs[REG_COM7] <= com7_after_reset(wr_data);
        end else if (commit) begin
            regs[sub_addr] <= data_byte;
        end
    end

    // Same-cycle commit and peek of one address returns the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_data <= 8'h00;
        end else begin
            dbg_data <= regs[dbg_addr];
        end
    end

endmodule

// File: tb/tb_sccb_slave.sv
module tb_sccb_slave;

    localparam int Q = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    wire        sda;
    logic       m_low;
    logic [7:0] dbg_addr;
    logic [7:0] dbg_data;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       id_err;
    logic       soft_rst;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int         n_wr = 0;
    int         n_rd = 0;
    int         n_id = 0;
    int         n_srst = 0;
    int         n_dut_low = 0;
    logic [7:0] last_wa = 8'h00;
    logic [7:0] last_wd = 8'h00;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    sccb_slave dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .id_err   (id_err),
        .soft_rst (soft_rst),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (wr_valid) begin
            n_wr++;
            last_wa = wr_addr;
            last_wd = wr_data;
        end
        if (rd_valid) n_rd++;
        if (id_err) n_id++;
        if (soft_rst) n_srst++;
        if (sda === 1'b0 && !m_low) n_dut_low++;
    end

    task automatic bus_start();
        m_low = 1'b0; #(Q);
        scl = 1'b1;   #(Q);
        m_low = 1'b1; #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; #(Q);
        scl = 1'b1;   #(Q);
        m_low = 1'b0; #(Q);
        #(2*Q);
    endtask

    task automatic write_bit(input logic b);
        m_low = ~b; #(Q);
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #(Q);
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0; #(Q);
        scl = 1'b1;   #(Q);
        b = sda;      #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic acked);
        logic bb;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(bb);
        acked = (bb == 1'b0);
    endtask

    task automatic recv_byte(output logic [7:0] d);
        logic bb;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bb);
            d[i] = bb;
        end
        write_bit(1'b1);
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] v);
        dbg_addr = a;
        repeat (2) @(negedge clk);
        v = dbg_data;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        #20;
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda); end
        checks++; if ({wr_valid, rd_valid, id_err, soft_rst, busy} !== 5'b0) begin
            errors++; $display("FAIL reset_pulses: got %b want 00000", {wr_valid, rd_valid, id_err, soft_rst, busy}); end
        checks++; if ({wr_addr, wr_data, dbg_data} !== 24'h0) begin
            errors++; $display("FAIL reset_data: got %h want 000000", {wr_addr, wr_data, dbg_data}); end
        reset = 1'b0;
        #(2*Q);
        peek(8'h3A, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_reg3a: got %h want 00", v); end
    endtask

    task automatic test_write();
        logic a1, a2, a3;
        logic [7:0] v;
        int w0;
        w0 = n_wr;
        bus_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
        send_byte(8'h42, a1);
        send_byte(8'h3A, a2);
        send_byte(8'h04, a3);
        bus_stop();
        checks++; if ({a1, a2, a3} !== 3'b111) begin errors++; $display("FAIL wr_acks: got %b want 111", {a1, a2, a3}); end
        checks++; if (n_wr !== w0 + 1) begin errors++; $display("FAIL wr_count: got %0d want %0d", n_wr - w0, 1); end
        checks++; if ({last_wa, last_wd} !== 16'h3A04) begin errors++; $display("FAIL wr_strobe: got %h want 3a04", {last_wa, last_wd}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle: got %b want 0", busy); end
        peek(8'h3A, v);
        checks++; if (v !== 8'h04) begin errors++; $display("FAIL wr_dbg: got %h want 04", v); end
    endtask

    task automatic test_bad_id();
        logic a0, a1, a2, a3;
        int l0, i0, w0;
        l0 = n_dut_low; i0 = n_id; w0 = n_wr;
        bus_start();
        send_byte(8'h60, a0);
        bus_stop();
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL badid_ack: got %b want 0", a0); end
        checks++; if (n_dut_low !== l0) begin errors++; $display("FAIL badid_drive: got %0d low cycles want 0", n_dut_low - l0); end
        checks++; if (n_id !== i0 + 1) begin errors++; $display("FAIL badid_err: got %0d want 1", n_id - i0); end
        checks++; if (n_wr !== w0) begin errors++; $display("FAIL badid_wr: got %0d want 0", n_wr - w0); end
        bus_start();
        send_byte(8'h42, a1);
        send_byte(8'h55, a2);
        send_byte(8'hA5, a3);
        bus_stop();
        checks++; if ({a1, a2, a3} !== 3'b111) begin errors++; $display("FAIL badid_next_acks: got %b want 111", {a1, a2, a3}); end
        checks++; if (n_wr !== w0 + 1 || {last_wa, last_wd} !== 16'h55A5) begin
            errors++; $display("FAIL badid_next_wr: got %0d %h want 1 55a5", n_wr - w0, {last_wa, last_wd}); end
    endtask

    task automatic test_read();
        logic a1, a2, a3;
        logic [7:0] d;
        int r0, w0;
        r0 = n_rd; w0 = n_wr;
        bus_start();
        send_byte(8'h42, a1);
        send_byte(8'h3A, a2);
        bus_stop();
        bus_start();
        send_byte(8'h43, a3);
        recv_byte(d);
        bus_stop();
        checks++; if ({a1, a2, a3} !== 3'b111) begin errors++; $display("FAIL rd_acks: got %b want 111", {a1, a2, a3}); end
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL rd_data: got %h want 04", d); end
        checks++; if (n_rd !== r0 + 1) begin errors++; $display("FAIL rd_count: got %0d want 1", n_rd - r0); end
        checks++; if (n_wr !== w0) begin errors++; $display("FAIL rd_nowr: got %0d want 0", n_wr - w0); end
    endtask

    task automatic test_soft_reset();
        logic a1, a2, a3;
        logic [7:0] v;
        int s0;
        s0 = n_srst;
        bus_start();
        send_byte(8'h42, a1);
        send_byte(8'h12, a2);
        send_byte(8'h80, a3);
        bus_stop();
        checks++; if (n_srst !== s0 + 1) begin errors++; $display("FAIL srst_count: got %0d want 1", n_srst - s0); end
        checks++; if ({last_wa, last_wd} !== 16'h1280) begin errors++; $display("FAIL srst_strobe: got %h want 1280", {last_wa, last_wd}); end
        peek(8'h3A, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL srst_reg3a: got %h want 00", v); end
        peek(8'h12, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL srst_reg12: got %h want 00", v); end
        peek(8'h55, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL srst_reg55: got %h want 00", v); end
    endtask

    task automatic test_repeated_start();
        logic a1, a2, a3, a4, a5;
        logic [7:0] v;
        int w0;
        w0 = n_wr;
        bus_start();
        send_byte(8'h42, a1);
        send_byte(8'h20, a2);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
        bus_start();
        send_byte(8'h42, a3);
        send_byte(8'h40, a4);
        send_byte(8'hD0, a5);
        bus_stop();
        checks++; if ({a1, a2, a3, a4, a5} !== 5'b11111) begin errors++; $display("FAIL rs_acks: got %b want 11111", {a1, a2, a3, a4, a5}); end
        checks++; if (n_wr !== w0 + 1 || {last_wa, last_wd} !== 16'h40D0) begin
            errors++; $display("FAIL rs_wr: got %0d %h want 1 40d0", n_wr - w0, {last_wa, last_wd}); end
        peek(8'h40, v);
        checks++; if (v !== 8'hD0) begin errors++; $display("FAIL rs_reg40: got %h want d0", v); end
        peek(8'h20, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL rs_reg20: got %h want 00", v); end
    endtask

    task automatic test_reset_mid();
        logic a1, a2, a3, a4, a5;
        logic [7:0] v;
        int w0, s0;
        bus_start();
        send_byte(8'h42, a1);
        send_byte(8'h11, a2);
        write_bit(1'b1); write_bit(1'b1); write_bit(1'b1); write_bit(1'b1);
        m_low = 1'b0; #(Q);
        scl = 1'b1;   #(Q);
        checks++; if (busy !== 1'b1 || {a1, a2} !== 2'b11) begin
            errors++; $display("FAIL rm_pre: got busy %b acks %b want 1 11", busy, {a1, a2}); end
        reset = 1'b1;
        #1;
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rm_sda: got %b want 1", sda); end
        checks++; if ({wr_valid, rd_valid, id_err, soft_rst, busy} !== 5'b0 || {wr_addr, wr_data, dbg_data} !== 24'h0) begin
            errors++; $display("FAIL rm_outputs: got %b %h want 00000 000000",
                               {wr_valid, rd_valid, id_err, soft_rst, busy}, {wr_addr, wr_data, dbg_data}); end
        #9;
        #(2*Q);
        reset = 1'b0;
        #(2*Q);
        w0 = n_wr; s0 = n_srst;
        bus_start();
        send_byte(8'h42, a3);
        send_byte(8'h11, a4);
        send_byte(8'h80, a5);
        bus_stop();
        checks++; if ({a3, a4, a5} !== 3'b111) begin errors++; $display("FAIL rm_acks: got %b want 111", {a3, a4, a5}); end
        checks++; if (n_wr !== w0 + 1 || {last_wa, last_wd} !== 16'h1180) begin
            errors++; $display("FAIL rm_wr: got %0d %h want 1 1180", n_wr - w0, {last_wa, last_wd}); end
        checks++; if (n_srst !== s0) begin errors++; $display("FAIL rm_srst: got %0d want 0", n_srst - s0); end
        peek(8'h11, v);
        checks++; if (v !== 8'h80) begin errors++; $display("FAIL rm_reg11: got %h want 80", v); end
    endtask

    initial begin
        reset    = 1'b1;
        scl      = 1'b1;
        m_low    = 1'b0;
        dbg_addr = 8'h00;
        test_reset();
        test_write();
        test_bad_id();
        test_read();
        test_soft_reset();
        test_repeated_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_slave.md
Name: sccb_slave

Overview:
Synthesizable SCCB responder modelling the OV7670 register-configuration port. It is the target end of our SCCB configuration master and is used in closed-loop simulation and in on-FPGA loopback of the camera init sequence. It samples the SCL/SDA bus with the system clock, decodes 3-phase write and 2-phase-write/2-phase-read transactions, and holds a 256x8 register file. Every accepted write is reported on a strobe interface.

Parameters:
DEV_ID, 7'h21, 7-bit device address; 8'h42 on the bus is a write, 8'h43 is a read.
SYNC_STAGES, 2, number of flip-flop synchronizer stages on SCL and SDA.

Ports:
clk        in     1  system clock, 100 MHz
reset      in     1  asynchronous, active-high
scl        in     1  SCCB clock from the master
sda        inout  1  SCCB data; the block drives only 1'b0 or 'z'
dbg_addr   in     8  register-file debug read address
dbg_data   out    8  regfile[dbg_addr], registered, 1-cycle latency
wr_valid   out    1  1-cycle pulse when a register write is committed
wr_addr    out    8  sub-address of the committed write, valid with wr_valid
wr_data    out    8  data of the committed write, valid with wr_valid
rd_valid   out    1  1-cycle pulse when the read byte is loaded for transmit
id_err     out    1  1-cycle pulse on a device-ID mismatch
soft_rst   out    1  1-cycle pulse on a COM7 (0x12) write with bit7 set
busy       out    1  high from START until STOP

Behaviour:
- Reset values: all outputs 0, sda released ('z'), FSM in IDLE, regfile all 8'h00, sub_addr 8'h00.
- SCL and SDA pass through SYNC_STAGES flip-flops, then a 1-stage edge detector.
- The bus contract requires SCL high and low times of at least 4 clk each.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- START in any state goes to ID_BYTE, including a repeated START; the bit counter clears and sda is released.
- STOP in any state goes to IDLE and releases sda. A partially received byte is discarded.
- Bits are sampled on the SCL rising edge, MSB first. The bit counter is 0..7, and the 9th clock is the ACK slot.
- The slave drives its ACK (sda=0) starting on the SCL falling edge after bit 8 and releases it on the next SCL falling edge.
- FSM states: IDLE, ID_BYTE, ID_ACK, SUB_BYTE, SUB_ACK, DATA_BYTE, DATA_ACK, RD_BYTE, RD_ACK, IGNORE.
- ID_BYTE byte handling:
  - {DEV_ID,0}: go to ID_ACK, then SUB_BYTE.
  - {DEV_ID,1}: go to ID_ACK, then RD_BYTE.
  - Any other byte: no ACK, id_err pulses 1 clk after the 8th rising edge, go to IGNORE.
- SUB_BYTE: latch sub_addr, ACK, go to DATA_BYTE.
- DATA_BYTE: ACK, then commit. On the SCL falling edge that starts DATA_ACK:
  - regfile[sub_addr] is written.
  - wr_valid, wr_addr and wr_data are asserted for 1 clk.
  - After the ACK slot the FSM goes to IGNORE.
  - sub_addr does not auto-increment; extra bytes are not ACKed.
- Soft reset: a write of data with bit7=1 to addr 8'h12 pulses soft_rst in the commit cycle. On the next clk all 256 registers clear to 8'h00, and 0x12 stores data & 8'h7F.
- Read (RD_BYTE):
  - On the SCL falling edge ending the ID ACK, regfile[sub_addr] is loaded into the tx shift register and rd_valid pulses.
  - The MSB is driven immediately. Each following bit is driven after an SCL falling edge: '0' drives low, '1' releases.
  - After 8 bits sda is released for the master's ACK/NACK (RD_ACK), then the FSM goes to IGNORE.
  - The master is expected to NACK; an ACK is treated the same.
- IGNORE: sda released; the FSM waits for START or STOP.
- A read without a prior 2-phase write returns regfile[sub_addr] using the last latched sub_addr.
- A write commit and a dbg_addr read of the same address in the same cycle returns the old value.
- Async reset mid-transaction: the block immediately returns to reset values, and the bus is released within 0 clk.

Decomposition:
- Package sccb_pkg holds:
  - state enum sccb_slv_state_t
  - constants SCCB_ID_WR=8'h42, SCCB_ID_RD=8'h43, REG_COM7=8'h12, COM7_RST_BIT=7
- Sub-module sccb_line_sync contains the synchronizers, edge detect and start/stop detect. Its outputs are scl_rise, scl_fall, sda_s, start_det, stop_det.

Test Plan:
- Write 42,3A,04 + STOP -> sda low in all three ACK slots; one wr_valid with wr_addr=3A, wr_data=04; dbg_addr=3A gives dbg_data=04.
- Byte 60 after START -> sda never driven low, id_err pulses once, no wr_valid, next valid transaction succeeds.
- Write 42,3A + STOP, then START 43 -> rd_valid pulses once; master samples 8'h04 (after the prior write); no wr_valid.
- Write 42,12,80 -> soft_rst pulses once; earlier reg 3A reads 00; reg 12 reads 00.
- Repeated START after 5 data bits, then write 42,40,D0 -> no commit for the aborted byte; one wr_valid with 40/D0.
- Assert reset during DATA_BYTE bit 4 -> sda 'z' and all outputs 0 immediately; a subsequent write 42,11,80 commits correctly.
